// File: rtl/spy_mem_if.sv
// Config, control and state-port signals of the spy memory controller.
// slave is the controller side, master the config/region side.
interface spy_mem_if #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int FAW = 2
);
    logic          cfg_we;
    logic          cfg_re;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [DW-1:0] cfg_rdata;
    logic          cfg_rvalid;
    logic          cfg_busy;
    logic          msk;
    logic          gcapture;
    logic          grestore;
    logic           st_req;
    logic           st_we;
    logic [FAW-1:0] st_fa;
    logic [3:0]     st_wo;
    logic [DW-1:0]  st_wdata;
    logic [DW-1:0]  st_rdata;
    logic           st_ack;
    logic [DW-1:0]  signature;
    logic           done;

    modport slave (
        input  cfg_we, cfg_re, cfg_addr, cfg_wdata, msk, gcapture, grestore,
               st_rdata, st_ack,
        output cfg_rdata, cfg_rvalid, cfg_busy, st_req, st_we, st_fa, st_wo,
               st_wdata, signature, done
    );

    modport master (
        output cfg_we, cfg_re, cfg_addr, cfg_wdata, msk, gcapture, grestore,
               st_rdata, st_ack,
        input  cfg_rdata, cfg_rvalid, cfg_busy, st_req, st_we, st_fa, st_wo,
               st_wdata, signature, done
    );
endinterface

// File: rtl/spy_mem_ctrl.sv
// Spy memory for a reconfigurable region: config-port access with a running
// XOR signature of logic words, plus capture/restore walks over state words.
module spy_mem_ctrl #(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_WORDS = 4,
    parameter int DW          = 32
) (
    input  logic     clk,
    input  logic     rstn,
    spy_mem_if.slave bus
);
    localparam int DEPTH = NUM_FRAMES * FRAME_WORDS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FAW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [FAW-1:0] LAST_FA = FAW'(NUM_FRAMES - 1);
    localparam logic [3:0]     LAST_WO = 4'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CAP, RST, DONE} state_t;

    state_t         state;
    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  sig;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           busy;
    logic           req;
    logic           we;
    logic           done_q;
    logic [FAW-1:0] fa;
    logic [3:0]     wo;

    logic          cfg_in_range;
    logic          cfg_off0;
    logic          cfg_wr;
    logic          cfg_rd;
    logic          xfer;
    logic          cap_wr;
    logic [AW-1:0] st_addr;

    assign cfg_in_range = {1'b0, bus.cfg_addr} < DEPTH_L;
    assign cfg_off0     = (int'(bus.cfg_addr) % FRAME_WORDS) == 0;
    assign cfg_wr       = bus.cfg_we && !busy && cfg_in_range;
    assign cfg_rd       = bus.cfg_re && !busy;
    assign xfer         = req && bus.st_ack;
    assign cap_wr       = xfer && (state == CAP);
    assign st_addr      = AW'(int'(fa) * FRAME_WORDS + int'(wo));

    assign bus.cfg_rdata  = rdata;
    assign bus.cfg_rvalid = rvalid;
    assign bus.cfg_busy   = busy;
    assign bus.st_req     = req;
    assign bus.st_we      = we;
    assign bus.st_fa      = fa;
    assign bus.st_wo      = wo;
    assign bus.st_wdata   = (req && we) ? mem[st_addr] : '0;
    assign bus.signature  = sig;
    assign bus.done       = done_q;

    // Config writes are locked out while busy, so they never race capture writes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sig    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= cfg_rd;
            if (cfg_rd)
                rdata <= (!cfg_in_range || (bus.msk && !cfg_off0)) ? '0 : mem[bus.cfg_addr];
            if (cfg_wr) begin
                mem[bus.cfg_addr] <= bus.cfg_wdata;
                if (cfg_off0) sig <= sig ^ mem[bus.cfg_addr] ^ bus.cfg_wdata;
            end else if (cap_wr) begin
                mem[st_addr] <= bus.st_rdata;
            end
        end
    end

    // Walk offsets 1..FRAME_WORDS-1 of each frame; offset 0 (logic data) is skipped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            req    <= 1'b0;
            we     <= 1'b0;
            done_q <= 1'b0;
            fa     <= '0;
            wo     <= 4'd1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.gcapture || bus.grestore) begin
                        state <= bus.gcapture ? CAP : RST;
                        busy  <= 1'b1;
                        req   <= 1'b1;
                        we    <= !bus.gcapture;
                        fa    <= '0;
                        wo    <= 4'd1;
                    end
                end
                CAP, RST: begin
                    if (xfer) begin
                        if (fa == LAST_FA && wo == LAST_WO) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            req    <= 1'b0;
                            we     <= 1'b0;
                            done_q <= 1'b1;
                            fa     <= '0;
                            wo     <= 4'd1;
                        end else if (wo == LAST_WO) begin
                            fa <= fa + 1'b1;
                            wo <= 4'd1;
                        end else begin
                            wo <= wo + 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spy_mem_ctrl.sv
// Directed bench for spy_mem_ctrl: reference model of memory/signature,
// read results checked through an expected-data queue.
module tb_spy_mem_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spy_mem_if #(.DW(32), .AW(4), .FAW(2)) bif ();
    spy_mem_ctrl #(.NUM_FRAMES(4), .FRAME_WORDS(4), .DW(32)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif)
    );

    // Region returns {fa, wo} as its state data.
    assign bif.st_rdata = {16'h0, 6'h0, bif.st_fa, 4'h0, bif.st_wo};

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] rq [$];
    logic [31:0] mem_m [16];
    logic [31:0] sig_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bif.cfg_we = 1'b1; bif.cfg_addr = 4'(a); bif.cfg_wdata = d;
        tick();
        bif.cfg_we = 1'b0;
        if (a % 4 == 0) sig_m = sig_m ^ mem_m[a] ^ d;
        mem_m[a] = d;
    endtask

    task automatic rd(input int a, input logic m);
        rq.push_back((m && (a % 4 != 0)) ? 32'h0 : mem_m[a]);
        bif.cfg_re = 1'b1; bif.cfg_addr = 4'(a); bif.msk = m;
        tick();
        bif.cfg_re = 1'b0; bif.msk = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bif.cfg_rvalid === 1'b1) begin
            if (rq.size() == 0) chk("rvalid_unexpected", {31'b0, bif.cfg_rvalid}, 32'd0);
            else                chk("rdata", bif.cfg_rdata, rq.pop_front());
        end
    end

    initial begin
        int n, c, t, a;
        bif.cfg_we = 0; bif.cfg_re = 0; bif.cfg_addr = '0; bif.cfg_wdata = '0;
        bif.msk = 0; bif.gcapture = 0; bif.grestore = 0; bif.st_ack = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        sig_m = '0;
        tick(); tick();
        rstn = 1'b1;

        chk("rst_busy",   32'(bif.cfg_busy),   0);
        chk("rst_req",    32'(bif.st_req),     0);
        chk("rst_we",     32'(bif.st_we),      0);
        chk("rst_done",   32'(bif.done),       0);
        chk("rst_rvalid", 32'(bif.cfg_rvalid), 0);
        chk("rst_fa",     32'(bif.st_fa),      0);
        chk("rst_wo",     32'(bif.st_wo),      1);
        chk("rst_sig",    bif.signature,       0);
        chk("rst_rdata",  bif.cfg_rdata,       0);
        chk("rst_wdata",  bif.st_wdata,        0);

        // signature tracking
        wr(0, 32'hA5A5_0000);
        wr(4, 32'h0000_5A5A);
        chk("sig_two_writes", bif.signature, 32'hA5A5_5A5A);
        wr(0, 32'h0);
        chk("sig_overwrite", bif.signature, 32'h0000_5A5A);
        wr(5, 32'h1234);
        chk("sig_state_word", bif.signature, 32'h0000_5A5A);

        // masked reads
        wr(5, 32'hDEAD);
        wr(0, 32'hCAFE);
        chk("sig_model", bif.signature, sig_m);
        rd(5, 1'b1);
        rd(5, 1'b0);
        rd(0, 1'b1);
        rd(4, 1'b1);

        // same-cycle write+read returns old value
        wr(1, 32'h1111);
        rq.push_back(mem_m[1]);
        bif.cfg_we = 1; bif.cfg_re = 1; bif.cfg_addr = 4'd1; bif.cfg_wdata = 32'h2222;
        tick();
        bif.cfg_we = 0; bif.cfg_re = 0;
        mem_m[1] = 32'h2222;
        rd(1, 1'b0);

        // capture with ack tied high
        bif.st_ack = 1; bif.gcapture = 1;
        tick();
        bif.gcapture = 0;
        n = 0;
        while (bif.cfg_busy === 1'b1 && n < 100) begin
            chk("cap_req", 32'(bif.st_req), 1);
            chk("cap_we",  32'(bif.st_we),  0);
            chk("cap_fa",  32'(bif.st_fa),  n / 3);
            chk("cap_wo",  32'(bif.st_wo),  n % 3 + 1);
            n++;
            tick();
        end
        chk("cap_busy_cycles", n, 12);
        chk("cap_done", 32'(bif.done), 1);
        chk("cap_req_off", 32'(bif.st_req), 0);
        for (int f = 0; f < 4; f++)
            for (int w = 1; w < 4; w++) mem_m[f*4+w] = (f << 8) | w;
        tick();
        chk("cap_done_pulse", 32'(bif.done), 0);
        chk("cap_sig", bif.signature, sig_m);
        rd(6, 1'b0);
        for (int i = 0; i < 16; i++) rd(i, 1'b0);

        // restore, ack every third cycle
        bif.st_ack = 0; bif.grestore = 1;
        tick();
        bif.grestore = 0;
        c = 0; t = 0;
        while (bif.cfg_busy === 1'b1 && c < 200) begin
            a = (t / 3) * 4 + t % 3 + 1;
            chk("rs_req",   32'(bif.st_req), 1);
            chk("rs_we",    32'(bif.st_we),  1);
            chk("rs_fa",    32'(bif.st_fa),  t / 3);
            chk("rs_wo",    32'(bif.st_wo),  t % 3 + 1);
            chk("rs_wdata", bif.st_wdata,    mem_m[a]);
            bif.st_ack = (c % 3 == 2);
            tick();
            if (bif.st_ack) t++;
            bif.st_ack = 0;
            c++;
        end
        chk("rs_xfers", t, 12);
        chk("rs_done", 32'(bif.done), 1);
        tick();
        chk("rs_sig", bif.signature, sig_m);

        // simultaneous start, config access while busy
        bif.gcapture = 1; bif.grestore = 1;
        tick();
        bif.gcapture = 0; bif.grestore = 0;
        chk("both_we",   32'(bif.st_we),    0);
        chk("both_busy", 32'(bif.cfg_busy), 1);
        bif.cfg_we = 1; bif.cfg_addr = 4'd0; bif.cfg_wdata = 32'hFFFF_FFFF;
        tick();
        bif.cfg_we = 0;
        bif.cfg_re = 1;
        tick();
        bif.cfg_re = 0;
        chk("busy_wr_sig", bif.signature, sig_m);
        bif.st_ack = 1;
        n = 0;
        while (bif.cfg_busy === 1'b1 && n < 100) begin n++; tick(); end
        chk("both_xfers", n, 12);
        chk("both_done", 32'(bif.done), 1);
        tick();
        rd(0, 1'b0);

        // reset mid-capture
        bif.gcapture = 1;
        tick();
        bif.gcapture = 0;
        repeat (5) tick();
        chk("mid_fa", 32'(bif.st_fa), 1);
        chk("mid_wo", 32'(bif.st_wo), 3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        bif.st_ack = 0;
        chk("mid_rst_busy", 32'(bif.cfg_busy), 0);
        chk("mid_rst_req",  32'(bif.st_req),   0);
        chk("mid_rst_sig",  bif.signature,     0);
        chk("mid_rst_wo",   32'(bif.st_wo),    1);
        chk("mid_rst_done", 32'(bif.done),     0);
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        sig_m = '0;
        for (int i = 0; i < 16; i++) rd(i, 1'b0);

        tick(); tick();
        chk("rq_drained", 32'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spy_mem_ctrl.md
SPY_MEM_CTRL -- requirements
Module: spy_mem_ctrl

Interface
REQ-001 Parameter NUM_FRAMES, default 4: number of frames in the reconfigurable region's spy memory.
REQ-002 Parameter FRAME_WORDS, default 4, legal range 2-16: words per frame; offset 0 holds logic data, offsets 1..FRAME_WORDS-1 hold state data.
REQ-003 Parameter DW, default 32: word width in bits.
REQ-004 Derived: DEPTH = NUM_FRAMES*FRAME_WORDS; AW = clog2(DEPTH); word address = frame*FRAME_WORDS + offset.
REQ-005 One clock, clk; reset is synchronous and active-low, rstn.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 cfg_we  in  1  config-port write strobe.
REQ-009 cfg_re  in  1  config-port read strobe.
REQ-010 cfg_addr  in  AW  config word address.
REQ-011 cfg_wdata  in  DW  config write data.
REQ-012 cfg_rdata  out  DW  config read data.
REQ-013 cfg_rvalid  out  1  read-data-valid pulse.
REQ-014 cfg_busy  out  1  capture/restore sequence in progress.
REQ-015 msk  in  1  readback mask for state words.
REQ-016 gcapture  in  1  start capture: region state -> spy memory.
REQ-017 grestore  in  1  start restore: spy memory -> region state.
REQ-018 st_req  out  1  state-port transfer request.
REQ-019 st_we  out  1  state-port direction; 1 = restore write, 0 = capture read.
REQ-020 st_fa  out  clog2(NUM_FRAMES)  state-port frame address.
REQ-021 st_wo  out  4  state-port word offset, range 1..FRAME_WORDS-1.
REQ-022 st_wdata  out  DW  restore data to the region.
REQ-023 st_rdata  in  DW  capture data from the region.
REQ-024 st_ack  in  1  region acknowledge; transfer completes on any cycle with st_req && st_ack.
REQ-025 signature  out  DW  XOR of all offset-0 words.
REQ-026 done  out  1  one-cycle pulse when capture/restore finishes.

Function
REQ-027 Config write with !cfg_busy and cfg_addr < DEPTH: mem[cfg_addr] <= cfg_wdata on the same edge.
REQ-028 Signature update is incremental: a write to an offset-0 word sets signature <= signature ^ old ^ new in the same cycle as the write; offset≠0 writes leave signature unchanged.
REQ-029 Config read with !cfg_busy: cfg_rvalid=1 and cfg_rdata valid exactly one cycle after cfg_re; cfg_rvalid is otherwise 0.
REQ-030 Read data = 0 when addr >= DEPTH, or when msk=1 and offset≠0; otherwise the stored word.
REQ-031 cfg_we and cfg_re in the same cycle: the write is performed and the read returns the pre-write value.
REQ-032 cfg_we/cfg_re while cfg_busy=1, or writes with addr >= DEPTH: ignored, no rvalid, no state change.
REQ-033 FSM states: IDLE, CAP, RST, DONE.
REQ-034 IDLE -> CAP on gcapture; IDLE -> RST on grestore only; both asserted together -> CAP.
REQ-035 gcapture/grestore outside IDLE: ignored.
REQ-036 CAP/RST walk frames 0..NUM_FRAMES-1, offsets 1..FRAME_WORDS-1 within each frame, in ascending order: NUM_FRAMES*(FRAME_WORDS-1) transfers.
REQ-037 During each transfer st_req=1 with st_fa/st_wo/st_we stable until st_ack; no timeout.
REQ-038 CAP: on a completing transfer, st_rdata is written to mem[fa*FRAME_WORDS+wo]; signature unchanged.
REQ-039 RST: st_wdata = mem[fa*FRAME_WORDS+wo], driven combinationally and held with st_req.
REQ-040 After the last transfer -> DONE for one cycle (done=1, cfg_busy=0, st_req=0), then -> IDLE.
REQ-041 cfg_busy = 1 in CAP and RST only; with st_ack tied high, one transfer completes per cycle.

Reset
REQ-042 rstn=0 at a clock edge, including mid-sequence: FSM -> IDLE; all mem words, signature, cfg_rdata and st_wdata = 0; cfg_rvalid, cfg_busy, st_req, st_we, done = 0; st_fa = 0; st_wo = 1.

Verification
REQ-043 Write 0xA5A50000 to addr 0 and 0x00005A5A to addr 4 -> signature 0xA5A55A5A; write 0 to addr 0 -> signature 0x00005A5A; write 0x1234 to addr 5 -> signature unchanged.
REQ-044 Write 0xDEAD to addr 5; read addr 5 with msk=1 -> rdata 0 next cycle; with msk=0 -> rdata 0xDEAD; read addr 0 with msk=1 -> stored value.
REQ-045 gcapture pulse, st_ack=1, st_rdata = {fa,wo} -> cfg_busy high 12 cycles; done on cycle 13; addr 6 reads 0x0102; signature unchanged.
REQ-046 grestore with st_ack asserted every third cycle -> 12 transfers; each st_wdata equals the stored word; addresses stable while waiting.
REQ-047 rstn low after the 5th capture transfer -> next cycle cfg_busy=0, st_req=0, all reads return 0, signature=0.
REQ-048 Simultaneous gcapture+grestore -> st_we=0 (capture); cfg_we to addr 0 during busy -> mem and signature unchanged.
